// File: rtl/geri_yaz_cok_kanal_pkg.sv
// Shared constants for the multi-channel write-back stage.
// Channel-0 result source encodings and arbiter mode selectors.
package geri_yaz_cok_kanal_pkg;

    // Channel-0 write-back source select; 2'b11 is illegal
    typedef enum logic [1:0] {
        GERIYAZ_BIB   = 2'd0,
        GERIYAZ_YURUT = 2'd1,
        GERIYAZ_PCART = 2'd2
    } geriyaz_sec_e;

    // Arbiter modes
    localparam int unsigned ONCELIK_SABIT = 0;
    localparam int unsigned ONCELIK_DONEN = 1;

endpackage

// File: rtl/geri_yaz_tampon.sv
// Per-channel FIFO for write-back entries ({address, data}).
// Ports: clk_i, rst_i (async, active-low), push_i, pop_i, veri_i (entry in),
//        veri_o (head entry), bos_o (empty), dolu_o (full), sayac_o (registered count).
// Push on full and pop on empty are ignored; DERINLIK must be a power of two.
module geri_yaz_tampon #(
    parameter int unsigned GENISLIK = 37,
    parameter int unsigned DERINLIK = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  logic [GENISLIK-1:0]              veri_i,
    output logic [GENISLIK-1:0]              veri_o,
    output logic                             bos_o,
    output logic                             dolu_o,
    output logic [$clog2(DERINLIK):0]        sayac_o
);

    localparam int unsigned PTR_BIT   = $clog2(DERINLIK);
    localparam int unsigned SAYAC_BIT = PTR_BIT + 1;

    logic [GENISLIK-1:0]  mem_q [DERINLIK];
    logic [GENISLIK-1:0]  mem_d [DERINLIK];
    logic [PTR_BIT-1:0]   yaz_ptr_q, yaz_ptr_d;
    logic [PTR_BIT-1:0]   oku_ptr_q, oku_ptr_d;
    logic [SAYAC_BIT-1:0] sayac_q, sayac_d;
    logic                 push_ok, pop_ok;

    // Next-state: storage write, pointer advance, occupancy update
    always_comb begin
        mem_d     = mem_q;
        yaz_ptr_d = yaz_ptr_q;
        oku_ptr_d = oku_ptr_q;
        sayac_d   = sayac_q;
        push_ok   = push_i && (sayac_q != SAYAC_BIT'(DERINLIK));
        pop_ok    = pop_i && (sayac_q != '0);
        if (push_ok) begin
            mem_d[yaz_ptr_q] = veri_i;
            yaz_ptr_d        = yaz_ptr_q + PTR_BIT'(1);
        end
        if (pop_ok) begin
            oku_ptr_d = oku_ptr_q + PTR_BIT'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   sayac_d = sayac_q + SAYAC_BIT'(1);
            2'b01:   sayac_d = sayac_q - SAYAC_BIT'(1);
            default: sayac_d = sayac_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DERINLIK); i++) begin
                mem_q[i] <= '0;
            end
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
            sayac_q   <= '0;
        end else begin
            mem_q     <= mem_d;
            yaz_ptr_q <= yaz_ptr_d;
            oku_ptr_q <= oku_ptr_d;
            sayac_q   <= sayac_d;
        end
    end

    assign veri_o  = mem_q[oku_ptr_q];
    assign bos_o   = (sayac_q == '0);
    assign dolu_o  = (sayac_q == SAYAC_BIT'(DERINLIK));
    assign sayac_o = sayac_q;

endmodule

// File: rtl/geri_yaz_cok_kanal.sv
// Multi-channel write-back stage: merges the main pipeline (channel 0) and
// KANAL_SAYISI-1 multi-cycle units onto one registered register-file write port.
// Ports: clk_i, rst_i (async, active-low); channel 0: boru_gecerli_i/boru_hazir_o,
//        sec_geri_yaz_i, rd_adres_i, rd_deger_i, bib_deger_i, program_sayaci_artmis_i,
//        yaz_yazmac_i; extra units: ek_gecerli_i/ek_hazir_o, ek_adres_i, ek_deger_i
//        (flattened, unit k at slice k); outputs: yaz_adres_o, yaz_deger_o,
//        yaz_yazmac_o, hatali_sec_o, mesgul_o.
module geri_yaz_cok_kanal
    import geri_yaz_cok_kanal_pkg::*;
#(
    parameter int unsigned KANAL_SAYISI    = 3,
    parameter int unsigned VERI_BIT        = 32,
    parameter int unsigned ADRES_BIT       = 5,
    parameter int unsigned TAMPON_DERINLIK = 2,
    parameter int unsigned ONCELIK_MODU    = ONCELIK_SABIT
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  boru_gecerli_i,
    output logic                                  boru_hazir_o,
    input  logic [1:0]                            sec_geri_yaz_i,
    input  logic [ADRES_BIT-1:0]                  rd_adres_i,
    input  logic [VERI_BIT-1:0]                   rd_deger_i,
    input  logic [VERI_BIT-1:0]                   bib_deger_i,
    input  logic [VERI_BIT-1:0]                   program_sayaci_artmis_i,
    input  logic                                  yaz_yazmac_i,
    input  logic [KANAL_SAYISI-2:0]               ek_gecerli_i,
    output logic [KANAL_SAYISI-2:0]               ek_hazir_o,
    input  logic [(KANAL_SAYISI-1)*ADRES_BIT-1:0] ek_adres_i,
    input  logic [(KANAL_SAYISI-1)*VERI_BIT-1:0]  ek_deger_i,
    output logic [ADRES_BIT-1:0]                  yaz_adres_o,
    output logic [VERI_BIT-1:0]                   yaz_deger_o,
    output logic                                  yaz_yazmac_o,
    output logic                                  hatali_sec_o,
    output logic                                  mesgul_o
);

    localparam int unsigned GIRIS_BIT = ADRES_BIT + VERI_BIT;
    localparam int unsigned IDX_BIT   = $clog2(KANAL_SAYISI);
    localparam int unsigned SAYAC_BIT = $clog2(TAMPON_DERINLIK) + 1;

    logic [KANAL_SAYISI-1:0] push, pop, bos, dolu, hazir;
    logic [GIRIS_BIT-1:0]    giris [KANAL_SAYISI];
    logic [GIRIS_BIT-1:0]    cikis [KANAL_SAYISI];
    logic [SAYAC_BIT-1:0]    sayac [KANAL_SAYISI];

    logic [VERI_BIT-1:0]  boru_deger;
    logic                 sec_gecerli;
    logic                 boru_kabul;
    logic                 boru_push;

    logic [IDX_BIT-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_BIT-1:0]   secilen;
    logic                 var_mi;
    int unsigned          aday;

    logic [ADRES_BIT-1:0] yaz_adres_q, yaz_adres_d;
    logic [VERI_BIT-1:0]  yaz_deger_q, yaz_deger_d;
    logic                 yaz_yazmac_q, yaz_yazmac_d;
    logic                 hatali_q, hatali_d;
    logic                 mesgul_c;

    // Channel-0 source mux and accept/enqueue filter
    always_comb begin
        boru_deger  = rd_deger_i;
        sec_gecerli = 1'b1;
        unique case (sec_geri_yaz_i)
            GERIYAZ_BIB:   boru_deger = bib_deger_i;
            GERIYAZ_YURUT: boru_deger = rd_deger_i;
            GERIYAZ_PCART: boru_deger = program_sayaci_artmis_i;
            default:       sec_gecerli = 1'b0;
        endcase
        boru_kabul = boru_gecerli_i && hazir[0];
        // Accepted entries with no real write (x0, disabled, bad select) are dropped
        boru_push  = boru_kabul && yaz_yazmac_i && (rd_adres_i != '0) && sec_gecerli;
    end

    // Per-channel FIFOs; ready comes from registered occupancy only
    for (genvar k = 0; k < int'(KANAL_SAYISI); k++) begin : g_kanal
        if (k == 0) begin : g_boru
            assign giris[k] = {rd_adres_i, boru_deger};
            assign push[k]  = boru_push;
        end else begin : g_ek
            logic [ADRES_BIT-1:0] adres;
            assign adres    = ek_adres_i[(k-1)*ADRES_BIT +: ADRES_BIT];
            assign giris[k] = {adres, ek_deger_i[(k-1)*VERI_BIT +: VERI_BIT]};
            assign push[k]  = ek_gecerli_i[k-1] && hazir[k] && (adres != '0);
        end

        geri_yaz_tampon #(
            .GENISLIK (GIRIS_BIT),
            .DERINLIK (TAMPON_DERINLIK)
        ) u_tampon (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[k]),
            .pop_i   (pop[k]),
            .veri_i  (giris[k]),
            .veri_o  (cikis[k]),
            .bos_o   (bos[k]),
            .dolu_o  (dolu[k]),
            .sayac_o (sayac[k])
        );

        assign hazir[k] = rst_i && !dolu[k];
    end

    // Arbiter and write-port next state
    always_comb begin
        pop     = '0;
        secilen = '0;
        var_mi  = 1'b0;
        aday    = 0;
        for (int i = 0; i < int'(KANAL_SAYISI); i++) begin
            // Round-robin scans from the channel after the last grant
            aday = (ONCELIK_MODU == ONCELIK_DONEN) ?
                   (32'(rr_ptr_q) + 32'(i) + 32'd1) % KANAL_SAYISI : 32'(i);
            if (!var_mi && !bos[IDX_BIT'(aday)]) begin
                var_mi  = 1'b1;
                secilen = IDX_BIT'(aday);
            end
        end
        if (var_mi) begin
            pop[secilen] = 1'b1;
        end

        rr_ptr_d     = var_mi ? secilen : rr_ptr_q;
        yaz_yazmac_d = var_mi;
        yaz_adres_d  = yaz_adres_q;
        yaz_deger_d  = yaz_deger_q;
        if (var_mi) begin
            yaz_adres_d = cikis[secilen][GIRIS_BIT-1 -: ADRES_BIT];
            yaz_deger_d = cikis[secilen][VERI_BIT-1:0];
        end
        hatali_d = boru_kabul && !sec_gecerli;
    end

    // Busy while anything is buffered or a write is on the port
    always_comb begin
        mesgul_c = yaz_yazmac_q;
        for (int i = 0; i < int'(KANAL_SAYISI); i++) begin
            if (sayac[i] != '0) begin
                mesgul_c = 1'b1;
            end
        end
    end

    // Output and pointer registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_ptr_q     <= IDX_BIT'(KANAL_SAYISI - 1);
            yaz_adres_q  <= '0;
            yaz_deger_q  <= '0;
            yaz_yazmac_q <= 1'b0;
            hatali_q     <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            yaz_adres_q  <= yaz_adres_d;
            yaz_deger_q  <= yaz_deger_d;
            yaz_yazmac_q <= yaz_yazmac_d;
            hatali_q     <= hatali_d;
        end
    end

    assign boru_hazir_o = hazir[0];
    assign ek_hazir_o   = hazir[KANAL_SAYISI-1:1];
    assign yaz_adres_o  = yaz_adres_q;
    assign yaz_deger_o  = yaz_deger_q;
    assign yaz_yazmac_o = yaz_yazmac_q;
    assign hatali_sec_o = hatali_q;
    assign mesgul_o     = mesgul_c;

endmodule

// File: tb/tb_geri_yaz_cok_kanal.sv
// Directed self-checking bench: one fixed-priority and one round-robin instance
// share the same stimulus; expected values are hand-computed constants.
module tb_geri_yaz_cok_kanal;
    import geri_yaz_cok_kanal_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        boru_gecerli_i = 1'b0;
    logic [1:0]  sec_geri_yaz_i = 2'd0;
    logic [4:0]  rd_adres_i = '0;
    logic [31:0] rd_deger_i = '0;
    logic [31:0] bib_deger_i = '0;
    logic [31:0] program_sayaci_artmis_i = '0;
    logic        yaz_yazmac_i = 1'b0;
    logic [1:0]  ek_gecerli_i = '0;
    logic [9:0]  ek_adres_i = '0;
    logic [63:0] ek_deger_i = '0;

    logic        f_boru_hazir, r_boru_hazir;
    logic [1:0]  f_ek_hazir, r_ek_hazir;
    logic [4:0]  f_adres, r_adres;
    logic [31:0] f_deger, r_deger;
    logic        f_yaz, r_yaz, f_hatali, r_hatali, f_mesgul, r_mesgul;

    int unsigned dogrulama_sayisi = 0;
    int unsigned hata_sayisi = 0;

    always #5 clk_i = ~clk_i;

    geri_yaz_cok_kanal #(
        .KANAL_SAYISI(3), .VERI_BIT(32), .ADRES_BIT(5),
        .TAMPON_DERINLIK(2), .ONCELIK_MODU(ONCELIK_SABIT)
    ) u_sabit (
        .clk_i(clk_i), .rst_i(rst_i),
        .boru_gecerli_i(boru_gecerli_i), .boru_hazir_o(f_boru_hazir),
        .sec_geri_yaz_i(sec_geri_yaz_i), .rd_adres_i(rd_adres_i),
        .rd_deger_i(rd_deger_i), .bib_deger_i(bib_deger_i),
        .program_sayaci_artmis_i(program_sayaci_artmis_i),
        .yaz_yazmac_i(yaz_yazmac_i),
        .ek_gecerli_i(ek_gecerli_i), .ek_hazir_o(f_ek_hazir),
        .ek_adres_i(ek_adres_i), .ek_deger_i(ek_deger_i),
        .yaz_adres_o(f_adres), .yaz_deger_o(f_deger), .yaz_yazmac_o(f_yaz),
        .hatali_sec_o(f_hatali), .mesgul_o(f_mesgul)
    );

    geri_yaz_cok_kanal #(
        .KANAL_SAYISI(3), .VERI_BIT(32), .ADRES_BIT(5),
        .TAMPON_DERINLIK(2), .ONCELIK_MODU(ONCELIK_DONEN)
    ) u_donen (
        .clk_i(clk_i), .rst_i(rst_i),
        .boru_gecerli_i(boru_gecerli_i), .boru_hazir_o(r_boru_hazir),
        .sec_geri_yaz_i(sec_geri_yaz_i), .rd_adres_i(rd_adres_i),
        .rd_deger_i(rd_deger_i), .bib_deger_i(bib_deger_i),
        .program_sayaci_artmis_i(program_sayaci_artmis_i),
        .yaz_yazmac_i(yaz_yazmac_i),
        .ek_gecerli_i(ek_gecerli_i), .ek_hazir_o(r_ek_hazir),
        .ek_adres_i(ek_adres_i), .ek_deger_i(ek_deger_i),
        .yaz_adres_o(r_adres), .yaz_deger_o(r_deger), .yaz_yazmac_o(r_yaz),
        .hatali_sec_o(r_hatali), .mesgul_o(r_mesgul)
    );

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                           input logic [63:0] beklenen);
        dogrulama_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", etiket, gozlenen, beklenen);
        end
    endtask

    // Advance one cycle; samples are taken 1 ns after the rising edge
    task automatic adim();
        @(posedge clk_i);
        #1;
    endtask

    task automatic girisleri_sifirla();
        boru_gecerli_i = 1'b0;
        yaz_yazmac_i   = 1'b0;
        rd_adres_i     = '0;
        sec_geri_yaz_i = GERIYAZ_YURUT;
        ek_gecerli_i   = '0;
        ek_adres_i     = '0;
        ek_deger_i     = '0;
    endtask

    task automatic sifirla();
        girisleri_sifirla();
        rst_i = 1'b0;
        adim();
        rst_i = 1'b1;
        #1;
    endtask

    task automatic boru_sur(input logic [1:0] sec, input logic [4:0] rd, input logic yaz);
        boru_gecerli_i = 1'b1;
        sec_geri_yaz_i = sec;
        rd_adres_i     = rd;
        yaz_yazmac_i   = yaz;
    endtask

    initial begin
        // Reset values
        girisleri_sifirla();
        #12;
        kontrol("reset_yaz", 64'(f_yaz), 64'd0);
        kontrol("reset_adres", 64'(f_adres), 64'd0);
        kontrol("reset_deger", 64'(f_deger), 64'd0);
        kontrol("reset_hatali", 64'(f_hatali), 64'd0);
        kontrol("reset_boru_hazir", 64'(f_boru_hazir), 64'd0);
        kontrol("reset_ek_hazir", 64'(f_ek_hazir), 64'd0);
        kontrol("reset_mesgul", 64'(f_mesgul), 64'd0);
        #11 rst_i = 1'b1;
        adim();
        kontrol("hazir_after_reset", 64'(f_boru_hazir), 64'd1);

        // Single YURUT write, two-edge latency, one-cycle strobe
        rd_deger_i = 32'h1234_5678;
        boru_sur(GERIYAZ_YURUT, 5'd5, 1'b1);
        adim();
        girisleri_sifirla();
        kontrol("t1_no_strobe_yet", 64'(f_yaz), 64'd0);
        adim();
        kontrol("t1_strobe", 64'(f_yaz), 64'd1);
        kontrol("t1_adres", 64'(f_adres), 64'd5);
        kontrol("t1_deger", 64'(f_deger), 64'h1234_5678);
        adim();
        kontrol("t1_strobe_end", 64'(f_yaz), 64'd0);
        kontrol("t1_adres_hold", 64'(f_adres), 64'd5);
        kontrol("t1_mesgul_idle", 64'(f_mesgul), 64'd0);

        // PCART then BIB back to back
        program_sayaci_artmis_i = 32'h0000_0104;
        boru_sur(GERIYAZ_PCART, 5'd1, 1'b1);
        adim();
        bib_deger_i = 32'hDEAD_BEEF;
        boru_sur(GERIYAZ_BIB, 5'd2, 1'b1);
        adim();
        girisleri_sifirla();
        kontrol("t2_w1_strobe", 64'(f_yaz), 64'd1);
        kontrol("t2_w1_adres", 64'(f_adres), 64'd1);
        kontrol("t2_w1_deger", 64'(f_deger), 64'h104);
        adim();
        kontrol("t2_w2_strobe", 64'(f_yaz), 64'd1);
        kontrol("t2_w2_adres", 64'(f_adres), 64'd2);
        kontrol("t2_w2_deger", 64'(f_deger), 64'hDEAD_BEEF);
        adim();
        kontrol("t2_idle", 64'(f_yaz), 64'd0);

        // Filtered entries: rd=0, write disabled, illegal select
        boru_sur(GERIYAZ_YURUT, 5'd0, 1'b1);
        adim();
        kontrol("t3_rd0_hatali", 64'(f_hatali), 64'd0);
        boru_sur(GERIYAZ_YURUT, 5'd3, 1'b0);
        adim();
        kontrol("t3_yaz0_hatali", 64'(f_hatali), 64'd0);
        kontrol("t3_rd0_no_strobe", 64'(f_yaz), 64'd0);
        boru_sur(2'b11, 5'd7, 1'b1);
        adim();
        girisleri_sifirla();
        kontrol("t3_illegal_pulse", 64'(f_hatali), 64'd1);
        kontrol("t3_yaz0_no_strobe", 64'(f_yaz), 64'd0);
        adim();
        kontrol("t3_pulse_end", 64'(f_hatali), 64'd0);
        kontrol("t3_illegal_no_strobe", 64'(f_yaz), 64'd0);
        adim();
        kontrol("t3_idle_strobe", 64'(f_yaz), 64'd0);
        kontrol("t3_idle_mesgul", 64'(f_mesgul), 64'd0);

        // All three channels in one cycle; RR pointer sits at 0 after earlier ch0 grants
        rd_deger_i = 32'hA0;
        boru_sur(GERIYAZ_YURUT, 5'd3, 1'b1);
        ek_gecerli_i = 2'b11;
        ek_adres_i   = {5'd5, 5'd4};
        ek_deger_i   = {32'hC2, 32'hC1};
        adim();
        girisleri_sifirla();
        adim();
        kontrol("t4_sabit_1", 64'(f_adres), 64'd3);
        kontrol("t4_sabit_1_deger", 64'(f_deger), 64'hA0);
        kontrol("t4_donen_1", 64'(r_adres), 64'd4);
        adim();
        kontrol("t4_sabit_2", 64'(f_adres), 64'd4);
        kontrol("t4_sabit_2_deger", 64'(f_deger), 64'hC1);
        kontrol("t4_donen_2", 64'(r_adres), 64'd5);
        adim();
        kontrol("t4_sabit_3", 64'(f_adres), 64'd5);
        kontrol("t4_sabit_3_deger", 64'(f_deger), 64'hC2);
        kontrol("t4_donen_3", 64'(r_adres), 64'd3);
        adim();
        kontrol("t4_idle", 64'(f_yaz), 64'd0);

        // Continuous traffic: RR rotates, fixed starves ch1 until ch0 stops
        sifirla();
        boru_sur(GERIYAZ_YURUT, 5'd3, 1'b1);
        ek_gecerli_i = 2'b11;
        ek_adres_i   = {5'd5, 5'd4};
        adim();
        kontrol("t5_ek_hazir_1accept", 64'(f_ek_hazir[0]), 64'd1);
        for (int i = 0; i < 6; i++) begin
            logic [4:0] rr_beklenen;
            adim();
            rr_beklenen = 5'(3 + (i % 3));
            kontrol($sformatf("t5_rr_grant%0d", i), 64'(r_adres), 64'(rr_beklenen));
            kontrol($sformatf("t5_rr_strobe%0d", i), 64'(r_yaz), 64'd1);
            kontrol($sformatf("t5_sabit_ch0_%0d", i), 64'(f_adres), 64'd3);
            kontrol($sformatf("t5_ek_hazir_full%0d", i), 64'(f_ek_hazir[0]), 64'd0);
        end
        boru_gecerli_i = 1'b0;
        adim();
        kontrol("t5_pop_cycle_hazir", 64'(f_ek_hazir[0]), 64'd0);
        kontrol("t5_last_ch0", 64'(f_adres), 64'd3);
        adim();
        kontrol("t5_ch1_write", 64'(f_adres), 64'd4);
        kontrol("t5_hazir_rises", 64'(f_ek_hazir[0]), 64'd1);

        // Async reset mid-cycle with two entries still buffered
        sifirla();
        boru_sur(GERIYAZ_YURUT, 5'd3, 1'b1);
        ek_gecerli_i = 2'b11;
        ek_adres_i   = {5'd5, 5'd4};
        adim();
        girisleri_sifirla();
        adim();
        kontrol("t6_pre_strobe", 64'(f_yaz), 64'd1);
        kontrol("t6_pre_mesgul", 64'(f_mesgul), 64'd1);
        #3 rst_i = 1'b0;
        #1;
        kontrol("t6_rst_yaz", 64'(f_yaz), 64'd0);
        kontrol("t6_rst_adres", 64'(f_adres), 64'd0);
        kontrol("t6_rst_deger", 64'(f_deger), 64'd0);
        kontrol("t6_rst_mesgul", 64'(f_mesgul), 64'd0);
        kontrol("t6_rst_hazir", 64'({f_ek_hazir, f_boru_hazir}), 64'd0);
        kontrol("t6_rst_rr_yaz", 64'(r_yaz), 64'd0);
        adim();
        #4 rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adim();
            kontrol($sformatf("t6_no_stale_f%0d", i), 64'(f_yaz), 64'd0);
            kontrol($sformatf("t6_no_stale_r%0d", i), 64'(r_yaz), 64'd0);
            kontrol($sformatf("t6_mesgul%0d", i), 64'({r_mesgul, f_mesgul}), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 dogrulama_sayisi, hata_sayisi);
        $finish;
    end

endmodule

// File: doc/geri_yaz_cok_kanal.md
Name: geri_yaz_cok_kanal

Overview:
Parametrised write-back stage that merges register-file writes from the main pipeline and from KANAL_SAYISI-1 multi-cycle result units (divider, FPU-like, load-miss return) onto the single register-file write port. Each channel has a valid/ready handshake and a small FIFO. An arbiter (fixed or round-robin) drains one entry per cycle into registered outputs. The main-pipeline channel keeps the GERIYAZ source mux (BIB / YURUT / PCART).

Parameters:
KANAL_SAYISI, 3, total channels; channel 0 is the main pipeline (min 2, max 8)
VERI_BIT, 32, register data width
ADRES_BIT, 5, register address width
TAMPON_DERINLIK, 2, FIFO entries per channel (power of two, >=2)
ONCELIK_MODU, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
boru_gecerli_i  in  1  channel-0 entry valid
boru_hazir_o  out  1  channel-0 can accept
sec_geri_yaz_i  in  2  channel-0 source select (`GERIYAZ_BIB / `GERIYAZ_YURUT / `GERIYAZ_PCART)
rd_adres_i  in  ADRES_BIT  channel-0 destination
rd_deger_i  in  VERI_BIT  execute result
bib_deger_i  in  VERI_BIT  memory load data
program_sayaci_artmis_i  in  VERI_BIT  PC+4
yaz_yazmac_i  in  1  channel-0 write enable
ek_gecerli_i  in  KANAL_SAYISI-1  per-unit valid
ek_hazir_o  out  KANAL_SAYISI-1  per-unit ready
ek_adres_i  in  (KANAL_SAYISI-1)*ADRES_BIT  flattened destinations; unit k at slice k
ek_deger_i  in  (KANAL_SAYISI-1)*VERI_BIT  flattened results
yaz_adres_o  out  ADRES_BIT  register-file write address (registered)
yaz_deger_o  out  VERI_BIT  register-file write data (registered)
yaz_yazmac_o  out  1  register-file write strobe (registered)
hatali_sec_o  out  1  one-cycle pulse: channel 0 accepted an illegal sec_geri_yaz_i
mesgul_o  out  1  any FIFO non-empty or yaz_yazmac_o high

Behaviour:
- Reset (rst_i low, async): FIFOs empty; yaz_adres_o=0, yaz_deger_o=0, yaz_yazmac_o=0, hatali_sec_o=0; round-robin pointer = KANAL_SAYISI-1 (channel 0 first after reset); boru_hazir_o and ek_hazir_o forced 0 while rst_i is low.
- Handshake: a transfer occurs on a rising edge with gecerli & hazir. hazir = (FIFO count < TAMPON_DERINLIK), taken from registered count only. No full pass-through: on a full FIFO, hazir stays 0 in the pop cycle and rises the next cycle.
- Channel-0 value mux at accept: BIB -> bib_deger_i, YURUT -> rd_deger_i, PCART -> program_sayaci_artmis_i.
- Illegal select value: entry is accepted, not enqueued, and hatali_sec_o pulses the next cycle.
- Channel-0 filter: if yaz_yazmac_i=0 or rd_adres_i=0, the entry is accepted (handshake completes) but not enqueued.
- Extra-channel filter: writes with address 0 are accepted and dropped.
- Arbitration, combinational each cycle over non-empty FIFOs:
  - fixed mode: lowest index wins.
  - RR mode: search starts at pointer+1 mod KANAL_SAYISI; pointer takes the granted index only on a grant.
- Grant pops that FIFO head. On the next edge, yaz_adres_o/yaz_deger_o load the head and yaz_yazmac_o=1. With no grant, yaz_yazmac_o=0 and address/data hold their previous values.
- Latency: accepted at edge N into an empty FIFO with no competition -> yaz_yazmac_o high in the cycle after edge N+1. Throughput is 1 write/cycle total.
- Simultaneous push and pop on the same FIFO: count unchanged, order preserved (FIFO per channel).
- No ordering between channels. Same-rd hazards across channels are prevented by issue logic upstream, not here.
- Reset mid-operation: all buffered entries are discarded; no write strobe after reset assertion.

Decomposition:
- tanimlamalar.vh holds `GERIYAZ_BIB/`GERIYAZ_YURUT/`GERIYAZ_PCART and the new `ONCELIK_SABIT=0, `ONCELIK_DONEN=1.
- Sub-module geri_yaz_tampon:
  - parametrised FIFO (VERI_BIT+ADRES_BIT wide, TAMPON_DERINLIK deep), same async active-low reset.
  - ports: push/pop/veri/bos/dolu/sayac.
  - instantiated KANAL_SAYISI times in a generate loop.
- Arbiter stays inline.

Test Plan:
- Reset release, ch0 YURUT, rd=5, rd_deger=0x1234_5678 -> 2 edges later yaz_yazmac_o=1, yaz_adres_o=5, yaz_deger_o=0x1234_5678, one cycle only.
- ch0 sec=PCART, PC+4=0x0000_0104, rd=1; then sec=BIB, bib=0xDEAD_BEEF, rd=2 back-to-back -> consecutive writes (1,0x104), (2,0xDEADBEEF).
- ch0 rd=0, or yaz_yazmac_i=0; plus sec=2'b11 -> no strobe; hatali_sec_o pulses once for the 2'b11 case only.
- Fixed mode, channels 0,1,2 all valid in the same cycle with rd=3,4,5 -> write order 3,4,5. RR mode with continuous traffic -> grants cycle 0,1,2,0,... with no channel starved.
- Hold ch1 valid with the arbiter starved by fixed-priority ch0 traffic and TAMPON_DERINLIK=2 -> ek_hazir_o[0] drops after 2 accepts and rises the cycle after the first ch1 pop.
- Assert rst_i low asynchronously mid-cycle with 2 entries buffered -> outputs 0 immediately; after release, no stale writes and mesgul_o=0.
